// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, buffer state
// encoding and the ALU opcode map.
package alu_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_OPC_W   = 5;
  localparam int DEF_SHAMT_W = 5;
  localparam int DEF_TAG_W   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam logic [DEF_OPC_W-1:0] OP_ADD = 5'd0;
  localparam logic [DEF_OPC_W-1:0] OP_SUB = 5'd1;
  localparam logic [DEF_OPC_W-1:0] OP_AND = 5'd2;
  localparam logic [DEF_OPC_W-1:0] OP_OR  = 5'd3;
  localparam logic [DEF_OPC_W-1:0] OP_SLL = 5'd4;
  localparam logic [DEF_OPC_W-1:0] OP_SRA = 5'd5;

endpackage

// File: rtl/alu_pkt_reg.sv
// Enable-loaded operand packet register {A, B, opcode, shamt, tag}.
// The asynchronous clear guarantees that no stale packet survives a reset.
module alu_pkt_reg
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic [OPC_W-1:0]   i_opc,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [TAG_W-1:0]   i_tag,
  output logic [DATA_W-1:0]  o_a,
  output logic [DATA_W-1:0]  o_b,
  output logic [OPC_W-1:0]   o_opc,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [TAG_W-1:0]   o_tag
);

  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [OPC_W-1:0]   r_opc;
  logic [SHAMT_W-1:0] r_shamt;
  logic [TAG_W-1:0]   r_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_opc   <= '0;
      r_shamt <= '0;
      r_tag   <= '0;
    end else if (i_load) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_opc   <= i_opc;
      r_shamt <= i_shamt;
      r_tag   <= i_tag;
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_opc   = r_opc;
  assign o_shamt = r_shamt;
  assign o_tag   = r_tag;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer in front of the combinational ALU: registered operands,
// registered in_ready, FIFO order and a wrapping sequence tag per accepted packet.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_operandA_in,
  input  logic [DATA_W-1:0]  data_operandB_in,
  input  logic [OPC_W-1:0]   ctrl_ALUopcode_in,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_operandA,
  output logic [DATA_W-1:0]  data_operandB,
  output logic [OPC_W-1:0]   ctrl_ALUopcode,
  output logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [TAG_W-1:0]   seq_id
);

  buf_state_e         r_state;
  buf_state_e         w_state_nxt;
  logic               r_in_ready;
  logic [TAG_W-1:0]   r_tag;

  logic               w_accept;
  logic               w_consume;
  logic               w_main_ld;
  logic               w_main_from_skid;
  logic               w_skid_ld;

  logic [DATA_W-1:0]  w_skid_a;
  logic [DATA_W-1:0]  w_skid_b;
  logic [OPC_W-1:0]   w_skid_opc;
  logic [SHAMT_W-1:0] w_skid_shamt;
  logic [TAG_W-1:0]   w_skid_tag;

  logic [DATA_W-1:0]  w_main_a;
  logic [DATA_W-1:0]  w_main_b;
  logic [OPC_W-1:0]   w_main_opc;
  logic [SHAMT_W-1:0] w_main_shamt;
  logic [TAG_W-1:0]   w_main_tag;

  // A packet offered during a flush cycle is dropped, so it neither loads nor consumes a tag.
  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign out_valid = (r_state != ST_EMPTY);
  assign w_consume = out_valid & out_ready;
  assign in_ready  = r_in_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_main_ld   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_main_ld = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_skid_ld   = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt      = ST_ONE;
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready looks one state ahead so it never depends combinationally on out_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_accept) begin
        r_tag <= r_tag + 1'b1;
      end
    end
  end

  assign w_main_a     = w_main_from_skid ? w_skid_a     : data_operandA_in;
  assign w_main_b     = w_main_from_skid ? w_skid_b     : data_operandB_in;
  assign w_main_opc   = w_main_from_skid ? w_skid_opc   : ctrl_ALUopcode_in;
  assign w_main_shamt = w_main_from_skid ? w_skid_shamt : ctrl_shiftamt_in;
  assign w_main_tag   = w_main_from_skid ? w_skid_tag   : r_tag;

  alu_pkt_reg #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .SHAMT_W(SHAMT_W),
    .TAG_W  (TAG_W)
  ) u_main (
    .i_clk  (clock),
    .i_rst_n(reset_n),
    .i_load (w_main_ld),
    .i_a    (w_main_a),
    .i_b    (w_main_b),
    .i_opc  (w_main_opc),
    .i_shamt(w_main_shamt),
    .i_tag  (w_main_tag),
    .o_a    (data_operandA),
    .o_b    (data_operandB),
    .o_opc  (ctrl_ALUopcode),
    .o_shamt(ctrl_shiftamt),
    .o_tag  (seq_id)
  );

  alu_pkt_reg #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .SHAMT_W(SHAMT_W),
    .TAG_W  (TAG_W)
  ) u_skid (
    .i_clk  (clock),
    .i_rst_n(reset_n),
    .i_load (w_skid_ld),
    .i_a    (data_operandA_in),
    .i_b    (data_operandB_in),
    .i_opc  (ctrl_ALUopcode_in),
    .i_shamt(ctrl_shiftamt_in),
    .i_tag  (r_tag),
    .o_a    (w_skid_a),
    .o_b    (w_skid_b),
    .o_opc  (w_skid_opc),
    .o_shamt(w_skid_shamt),
    .o_tag  (w_skid_tag)
  );

endmodule
